// File: rtl/alu_pkg.sv
// Shared definitions for the ALU host interface.
//   - Default widths of UART bytes / ALU operands and the ALU opcode.
//   - ALU opcode encodings (as seen on the opcode field of a frame).
//   - State encoding of the host-interface sequencer.
package alu_pkg;

  localparam int unsigned ALU_NB_DATA      = 8;
  localparam int unsigned ALU_NB_OPERATION = 6;

  localparam logic [ALU_NB_OPERATION-1:0] ADD = 6'b100000;
  localparam logic [ALU_NB_OPERATION-1:0] SUB = 6'b100010;
  localparam logic [ALU_NB_OPERATION-1:0] AND = 6'b100100;
  localparam logic [ALU_NB_OPERATION-1:0] OR  = 6'b100101;
  localparam logic [ALU_NB_OPERATION-1:0] XOR = 6'b100110;
  localparam logic [ALU_NB_OPERATION-1:0] SRA = 6'b000011;
  localparam logic [ALU_NB_OPERATION-1:0] SRL = 6'b000010;
  localparam logic [ALU_NB_OPERATION-1:0] NOR = 6'b100111;

  typedef enum logic [2:0] {
    StWaitA  = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StExec   = 3'd3,
    StWaitTx = 3'd4
  } alu_intf_state_e;

endpackage

// File: rtl/alu_intf_timeout.sv
// Inactivity timer for the ALU host interface.
// Ports:
//   i_clock    system clock
//   i_reset    synchronous active-high reset
//   i_clear    clear the count (byte received or sequencer state change)
//   i_count    count enable (sequencer is mid-frame waiting for a byte)
//   o_expired  count has reached TIMEOUT_CYCLES-1 while counting
module alu_intf_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned     NB_CNT  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clear || !i_count) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_count && (cnt_q == CNT_MAX);

endmodule

// File: rtl/alu_host_intf.sv
// ALU host interface: collects operand A, operand B and opcode bytes from the
// UART receiver, drives them onto the ALU, captures the ALU result one cycle
// later and starts a UART transmission of it.
// Optional feature macro: ALU_INTF_TIMEOUT_EN (abandon a partial frame after
// TIMEOUT_CYCLES idle clocks in WAIT_B / WAIT_OP).
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_rx_data, i_rx_done  received byte and its single-cycle strobe
//   i_alu_result          combinational ALU result
//   i_tx_done             transmitter finished strobe
//   o_data_a, o_data_b    ALU operands
//   o_op                  ALU opcode (low bits of the opcode byte)
//   o_tx_data, o_tx_start byte to transmit and its start pulse
//   o_busy                high while executing or transmitting
module alu_host_intf
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA        = ALU_NB_DATA,
  parameter int unsigned NB_OPERATION   = ALU_NB_OPERATION,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_DATA-1:0]      i_rx_data,
  input  logic                    i_rx_done,
  input  logic [NB_DATA-1:0]      i_alu_result,
  input  logic                    i_tx_done,
  output logic [NB_DATA-1:0]      o_data_a,
  output logic [NB_DATA-1:0]      o_data_b,
  output logic [NB_OPERATION-1:0] o_op,
  output logic [NB_DATA-1:0]      o_tx_data,
  output logic                    o_tx_start,
  output logic                    o_busy
);

  alu_intf_state_e         state_q, state_d;
  logic [NB_DATA-1:0]      data_a_q, data_a_d;
  logic [NB_DATA-1:0]      data_b_q, data_b_d;
  logic [NB_OPERATION-1:0] op_q, op_d;
  logic [NB_DATA-1:0]      tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    timeout;

`ifdef ALU_INTF_TIMEOUT_EN
  alu_intf_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (i_rx_done || (state_d != state_q)),
    .i_count   ((state_q == StWaitB) || (state_q == StWaitOp)),
    .o_expired (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    unique case (state_q)
      StWaitA: begin
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          state_d  = StWaitB;
        end
      end
      StWaitB: begin
        if (i_rx_done) begin
          data_b_d = i_rx_data;
          state_d  = StWaitOp;
        end
      end
      StWaitOp: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[NB_OPERATION-1:0];
          state_d = StExec;
        end
      end
      StExec: begin
        // ALU inputs have been stable for a full cycle; result is settled.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
      end
      StWaitTx: begin
        // tx_start_q marks the first WAIT_TX cycle, where tx_done is stale.
        if (i_tx_done && !tx_start_q) begin
          state_d = StWaitA;
        end
      end
      default: state_d = StWaitA;
    endcase
    // Only asserted in WAIT_B / WAIT_OP; operand registers keep their values.
    if (timeout) begin
      state_d = StWaitA;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StWaitA;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q == StExec) || (state_q == StWaitTx);

endmodule

// File: tb/tb_alu_host_intf.sv
module tb_alu_host_intf;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] alu_result;
  logic       tx_done = 1'b0;
  logic [7:0] data_a, data_b, tx_data;
  logic [5:0] op;
  logic       tx_start, busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  alu_host_intf #(
    .NB_DATA        (8),
    .NB_OPERATION   (6),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_alu_result (alu_result),
    .i_tx_done    (tx_done),
    .o_data_a     (data_a),
    .o_data_b     (data_b),
    .o_op         (op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy)
  );

  // Attached ALU.
  always_comb begin
    case (op)
      ADD:     alu_result = data_a + data_b;
      SUB:     alu_result = data_a - data_b;
      AND:     alu_result = data_a & data_b;
      OR:      alu_result = data_a | data_b;
      XOR:     alu_result = data_a ^ data_b;
      SRA:     alu_result = $unsigned($signed(data_a) >>> data_b);
      SRL:     alu_result = data_a >> data_b;
      NOR:     alu_result = ~(data_a | data_b);
      default: alu_result = 8'hFF;
    endcase
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle receive strobe; returns #1 after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Full frame including transmit handshake; returns what was seen in the start cycle.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          output logic [7:0] txd, output logic start_seen);
    send_byte(a);
    send_byte(b);
    send_byte(opb);
    tick();
    txd        = tx_data;
    start_seen = tx_start;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    nvec++; if (data_a !== 8'h00) begin nerr++; $display("FAIL reset_data_a got %h want 00", data_a); end
    nvec++; if (data_b !== 8'h00) begin nerr++; $display("FAIL reset_data_b got %h want 00", data_b); end
    nvec++; if (op !== 6'h00) begin nerr++; $display("FAIL reset_op got %h want 00", op); end
    nvec++; if (tx_data !== 8'h00) begin nerr++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    nvec++; if (tx_start !== 1'b0) begin nerr++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_add_timing();
    send_byte(8'h05);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL add_busy_wait_b got %b want 0", busy); end
    send_byte(8'h03);
    send_byte(8'h20);
    // cycle N+1
    nvec++; if (op !== 6'h20) begin nerr++; $display("FAIL add_op got %h want 20", op); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL add_busy_exec got %b want 1", busy); end
    nvec++; if (tx_start !== 1'b0) begin nerr++; $display("FAIL add_start_early got %b want 0", tx_start); end
    tick(); // cycle N+2
    nvec++; if (tx_start !== 1'b1) begin nerr++; $display("FAIL add_start got %b want 1", tx_start); end
    nvec++; if (tx_data !== 8'h08) begin nerr++; $display("FAIL add_tx_data got %h want 08", tx_data); end
    tick();
    nvec++; if (tx_start !== 1'b0) begin nerr++; $display("FAIL add_start_pulse got %b want 0", tx_start); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL add_busy_tx got %b want 1", busy); end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL add_busy_done got %b want 0", busy); end
    nvec++; if (data_a !== 8'h05) begin nerr++; $display("FAIL add_hold_a got %h want 05", data_a); end
    nvec++; if (data_b !== 8'h03) begin nerr++; $display("FAIL add_hold_b got %h want 03", data_b); end
    nvec++; if (tx_data !== 8'h08) begin nerr++; $display("FAIL add_hold_tx got %h want 08", tx_data); end
  endtask

  task automatic test_ops();
    logic [7:0] txd;
    logic       st;
    do_frame(8'h03, 8'h05, 8'h22, txd, st);
    nvec++; if (txd !== 8'hFE || st !== 1'b1) begin nerr++; $display("FAIL sub got %h/%b want fe/1", txd, st); end
    do_frame(8'h80, 8'h02, 8'h03, txd, st);
    nvec++; if (txd !== 8'hE0 || st !== 1'b1) begin nerr++; $display("FAIL sra got %h/%b want e0/1", txd, st); end
    do_frame(8'h10, 8'h22, 8'hE0, txd, st);
    nvec++; if (op !== 6'h20) begin nerr++; $display("FAIL upper_bits_op got %h want 20", op); end
    nvec++; if (txd !== 8'h32) begin nerr++; $display("FAIL upper_bits_add got %h want 32", txd); end
    do_frame(8'h12, 8'h34, 8'h3F, txd, st);
    nvec++; if (txd !== 8'hFF) begin nerr++; $display("FAIL illegal_op got %h want ff", txd); end
    do_frame(8'hF0, 8'h0F, 8'h27, txd, st);
    nvec++; if (txd !== 8'h00) begin nerr++; $display("FAIL nor got %h want 00", txd); end
  endtask

  task automatic test_dropped_bytes();
    logic [7:0] txd;
    logic       st;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    // EXEC: this byte must be dropped
    rx_data = 8'h55;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    nvec++; if (tx_start !== 1'b1 || tx_data !== 8'h03) begin
      nerr++; $display("FAIL drop_exec_start got %b/%h want 1/03", tx_start, tx_data);
    end
    nvec++; if (data_a !== 8'h01) begin nerr++; $display("FAIL drop_exec_a got %h want 01", data_a); end
    // tx_done in the start cycle is ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL early_tx_done busy got %b want 1", busy); end
    send_byte(8'h77);
    nvec++; if (busy !== 1'b1 || data_a !== 8'h01) begin
      nerr++; $display("FAIL drop_tx_byte got busy %b a %h want 1/01", busy, data_a);
    end
    // rx and tx done together: leave WAIT_TX, drop the byte
    rx_data = 8'h66;
    rx_done = 1'b1;
    tx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tx_done = 1'b0;
    nvec++; if (busy !== 1'b0 || data_a !== 8'h01) begin
      nerr++; $display("FAIL rx_tx_same got busy %b a %h want 0/01", busy, data_a);
    end
    do_frame(8'h09, 8'h04, 8'h22, txd, st);
    nvec++; if (data_a !== 8'h09 || data_b !== 8'h04) begin
      nerr++; $display("FAIL after_drop_ab got %h/%h want 09/04", data_a, data_b);
    end
    nvec++; if (txd !== 8'h05) begin nerr++; $display("FAIL after_drop_tx got %h want 05", txd); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] txd;
    logic       st;
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nvec++; if (data_a !== 8'h00 || data_b !== 8'h00 || op !== 6'h00) begin
      nerr++; $display("FAIL midreset_ops got %h/%h/%h want 00/00/00", data_a, data_b, op);
    end
    nvec++; if (tx_data !== 8'h00 || tx_start !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL midreset_tx got %h/%b/%b want 00/0/0", tx_data, tx_start, busy);
    end
    do_frame(8'h01, 8'h01, 8'h20, txd, st);
    nvec++; if (txd !== 8'h02 || st !== 1'b1) begin
      nerr++; $display("FAIL midreset_frame got %h/%b want 02/1", txd, st);
    end
  endtask

  task automatic test_idle();
    logic [7:0] txd;
    logic       st;
`ifdef ALU_INTF_TIMEOUT_EN
    send_byte(8'h07);
    repeat (16) tick();
    do_frame(8'h02, 8'h03, 8'h20, txd, st);
    nvec++; if (data_a !== 8'h02 || txd !== 8'h05) begin
      nerr++; $display("FAIL timeout_frame got a %h tx %h want 02/05", data_a, txd);
    end
`else
    send_byte(8'h07);
    repeat (10000) tick();
    nvec++; if (busy !== 1'b0 || data_a !== 8'h07) begin
      nerr++; $display("FAIL no_timeout_hold got busy %b a %h want 0/07", busy, data_a);
    end
    send_byte(8'h02);
    send_byte(8'h20);
    tick();
    txd = tx_data;
    st  = tx_start;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    nvec++; if (txd !== 8'h09 || st !== 1'b1) begin
      nerr++; $display("FAIL no_timeout_frame got %h/%b want 09/1", txd, st);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_ops();
    test_dropped_bytes();
    test_reset_midframe();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
